proc_param: RTL and testbench

Parametrised multicycle processor with a W-bit datapath, eight registers (R7 = program counter), and a synchronous-memory interface for instruction fetch, load and store. It adds AND, CMP, LD, ST and conditional branches with Z/N/C flags. It runs its own fetch/decode/execute FSM and pulses Done once per retired instruction. It sits between the board-level memory/IO wrapper and memory.

---
 rtl/proc_param_pkg.sv | 79 +++++++
 rtl/proc_param_if.sv | 30 +++
 rtl/proc_param_alu.sv | 46 ++++
 rtl/proc_param.sv | 183 ++++++++++++++++++
 tb/tb_proc_param.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/proc_param_pkg.sv
// proc_param shared definitions: opcodes, branch conditions,
// FSM states and bus-select codes.
package proc_param_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_NE = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] CC_CS = 3'b100;
  localparam logic [2:0] CC_PL = 3'b101;
  localparam logic [2:0] CC_MI = 3'b110;
  localparam logic [2:0] CC_NV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_E1,
    S_E2,
    S_E3
  } state_e;

  typedef enum logic [3:0] {
    SEL_R0,
    SEL_R1,
    SEL_R2,
    SEL_R3,
    SEL_R4,
    SEL_R5,
    SEL_R6,
    SEL_R7,
    SEL_G,
    SEL_D,
    SEL_D8,
    SEL_DIN
  } sel_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND
  } alu_op_e;

  function automatic sel_e rsel(input logic [2:0] r);
    return sel_e'({1'b0, r});
  endfunction

  function automatic logic cond_ok(
    input logic [2:0] cc,
    input logic       z,
    input logic       n,
    input logic       c
  );
    logic ok;
    unique case (cc)
      CC_AL:   ok = 1'b1;
      CC_EQ:   ok = z;
      CC_NE:   ok = !z;
      CC_CC:   ok = !c;
      CC_CS:   ok = c;
      CC_PL:   ok = !n;
      CC_MI:   ok = n;
      CC_NV:   ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/proc_param_if.sv
// proc_param memory/control port: run level, sync-memory
// read data, registered address/data/strobe and done pulse.
interface proc_param_if #(
  parameter int W = 16
);
  logic         Run;
  logic [W-1:0] DIN;
  logic [W-1:0] ADDR;
  logic [W-1:0] DOUT;
  logic         Wr;
  logic         Done;

  modport master (
    input  Run,
    input  DIN,
    output ADDR,
    output DOUT,
    output Wr,
    output Done
  );

  modport slave (
    output Run,
    output DIN,
    input  ADDR,
    input  DOUT,
    input  Wr,
    input  Done
  );
endinterface

// File: rtl/proc_param_alu.sv
// proc_param ALU: add/sub/and with Z, N and C.
// C is carry-out on add and borrow on sub.
module proc_param_alu
  import proc_param_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] r,
  output logic         z,
  output logic         n,
  output logic         c
);

  logic [W:0] sum;
  logic [W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  // bit W of the widened difference is set exactly when a < b
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    r = sum[W-1:0];
    c = sum[W];
    unique case (op)
      ALU_SUB: begin
        r = dif[W-1:0];
        c = dif[W];
      end
      ALU_AND: begin
        r = a & b;
        c = 1'b0;
      end
      default: begin
        r = sum[W-1:0];
        c = sum[W];
      end
    endcase
  end

  assign z = (r == '0);
  assign n = r[W-1];

endmodule

// File: rtl/proc_param.sv
// proc_param: multicycle W-bit processor, eight registers
// with R7 as PC, fetch/decode/execute FSM over sync memory.
module proc_param
  import proc_param_pkg::*;
#(
  parameter int W = 16
) (
  input logic          Clock,
  input logic          Resetn,
  proc_param_if.master mbus
);

  state_e       state;
  state_e       nxt;
  logic [W-1:0] rf [8];
  logic [W-1:0] a_q;
  logic [W-1:0] g_q;
  logic [15:0]  ir;
  logic         zf;
  logic         nf;
  logic         cf;

  logic [2:0]   opc;
  logic [2:0]   rx;
  logic [2:0]   ry;
  logic         m;
  logic [W-1:0] dz;
  logic [W-1:0] ds;
  logic [W-1:0] d8;
  logic         is_mv;
  logic         is_mvt;
  logic         is_b;
  logic         is_alu;
  logic         is_cmp;
  logic         is_ld;
  logic         is_st;
  logic         take;
  logic         done;

  sel_e         sel;
  logic [W-1:0] bus;
  alu_op_e      alu_op;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_r;
  logic         alu_z;
  logic         alu_n;
  logic         alu_c;

  assign opc = ir[15:13];
  assign m   = ir[12];
  assign rx  = ir[11:9];
  assign ry  = ir[2:0];

  assign dz = {{(W-9){1'b0}}, ir[8:0]};
  assign ds = {{(W-9){ir[8]}}, ir[8:0]};
  assign d8 = {ir[7:0], {(W-8){1'b0}}};

  assign is_mv  = (opc == OP_MV);
  assign is_mvt = (opc == OP_MVT) && m;
  assign is_b   = (opc == OP_MVT) && !m;
  assign is_alu = (opc == OP_ADD) || (opc == OP_SUB)
                || (opc == OP_AND);
  assign is_cmp = (opc == OP_CMP);
  assign is_ld  = (opc == OP_LD);
  assign is_st  = (opc == OP_ST);

  assign take = cond_ok(rx, zf, nf, cf);
  assign nxt  = mbus.Run ? S_F0 : S_IDLE;

  always_comb begin
    done = 1'b0;
    unique case (state)
      S_E1:    done = is_mv | is_mvt;
      S_E2:    done = is_cmp | (is_b & !take);
      S_E3:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign mbus.Done = done;

  always_comb begin
    sel = SEL_G;
    unique case (state)
      S_E1: begin
        unique case (1'b1)
          is_mvt:         sel = SEL_D8;
          is_b:           sel = SEL_R7;
          is_alu, is_cmp: sel = rsel(rx);
          is_mv:          sel = m ? SEL_D : rsel(ry);
          default:        sel = rsel(ry);
        endcase
      end
      S_E2: begin
        if (is_st) sel = rsel(rx);
        else       sel = m ? SEL_D : rsel(ry);
      end
      S_E3:    sel = is_ld ? SEL_DIN : SEL_G;
      default: sel = SEL_G;
    endcase
  end

  always_comb begin
    unique case (sel)
      SEL_G:   bus = g_q;
      SEL_D:   bus = dz;
      SEL_D8:  bus = d8;
      SEL_DIN: bus = mbus.DIN;
      default: bus = rf[sel[2:0]];
    endcase
  end

  assign alu_op = (is_b || opc == OP_ADD) ? ALU_ADD
                : (opc == OP_AND) ? ALU_AND : ALU_SUB;
  assign alu_b  = is_b ? ds : bus;

  proc_param_alu #(.W(W)) u_alu (
    .a  (a_q),
    .b  (alu_b),
    .op (alu_op),
    .r  (alu_r),
    .z  (alu_z),
    .n  (alu_n),
    .c  (alu_c)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      a_q       <= '0;
      g_q       <= '0;
      ir        <= '0;
      zf        <= 1'b0;
      nf        <= 1'b0;
      cf        <= 1'b0;
      mbus.ADDR <= '0;
      mbus.DOUT <= '0;
      mbus.Wr   <= 1'b0;
    end else begin
      mbus.Wr <= 1'b0;
      unique case (state)
        S_IDLE: if (mbus.Run) state <= S_F0;
        S_F0: begin
          mbus.ADDR <= rf[7];
          rf[7]     <= rf[7] + W'(1);
          state     <= S_F1;
        end
        S_F1: state <= S_F2;
        S_F2: begin
          ir    <= mbus.DIN[15:0];
          state <= S_E1;
        end
        S_E1: begin
          if (is_mv || is_mvt)      rf[rx]    <= bus;
          else if (is_ld || is_st)  mbus.ADDR <= bus;
          else                      a_q       <= bus;
          state <= done ? nxt : S_E2;
        end
        S_E2: begin
          if (is_st) begin
            mbus.DOUT <= bus;
            mbus.Wr   <= 1'b1;
          end else if (is_alu || is_cmp) begin
            g_q <= alu_r;
            zf  <= alu_z;
            nf  <= alu_n;
            cf  <= alu_c;
          end else if (is_b) begin
            g_q <= alu_r;
          end
          state <= done ? nxt : S_E3;
        end
        S_E3: begin
          if (!is_st) rf[is_b ? 3'd7 : rx] <= bus;
          state <= nxt;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: directed programs on W=16 and W=32 cores
// with sync memories, checking results, flags and timing.
module tb_proc_param;
  import proc_param_pkg::*;

  logic Clock;
  logic Resetn;

  proc_param_if #(.W(16)) b16 ();
  proc_param_if #(.W(32)) b32 ();

  proc_param #(.W(16)) dut16 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .mbus   (b16)
  );

  proc_param #(.W(32)) dut32 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .mbus   (b32)
  );

  logic [15:0] m16 [256];
  logic [31:0] m32 [256];
  logic        pk16;
  logic        pk32;
  logic [7:0]  pk_a;
  logic [15:0] pk_d;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [15:0] wr_a;
  logic [15:0] wr_d;
  logic        wr_done;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    b16.DIN <= m16[b16.ADDR[7:0]];
    if (pk16) m16[pk_a] <= pk_d;
    else if (b16.Wr) m16[b16.ADDR[7:0]] <= b16.DOUT;
  end

  always @(posedge Clock) begin
    b32.DIN <= m32[b32.ADDR[7:0]];
    if (pk32) m32[pk_a] <= {16'h0, pk_d};
    else if (b32.Wr) m32[b32.ADDR[7:0]] <= b32.DOUT;
  end

  always @(negedge Clock) begin
    if (b16.Wr) begin
      wr_cnt  = wr_cnt + 1;
      wr_a    = b16.ADDR;
      wr_d    = b16.DOUT;
      wr_done = b16.Done;
    end
  end

  function automatic logic [15:0] enc(
    input logic [2:0] op,
    input logic       mm,
    input logic [2:0] x,
    input logic [8:0] d
  );
    return {op, mm, x, d};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(
    input bit          w32,
    input logic [7:0]  a,
    input logic [15:0] d
  );
    pk_a = a;
    pk_d = d;
    pk16 = !w32;
    pk32 = w32;
    @(negedge Clock);
    pk16 = 1'b0;
    pk32 = 1'b0;
  endtask

  // counts cycles from F0 up to and including the Done cycle
  task automatic exec(
    input string tag,
    input int    exp,
    input bit    hold,
    input bit    w32
  );
    int n = 0;
    bit dn = 1'b0;
    if (w32) b32.Run = 1'b1;
    else     b16.Run = 1'b1;
    while (!dn && n < 40) begin
      @(negedge Clock);
      n++;
      dn = w32 ? b32.Done : b16.Done;
    end
    check({tag, " cycles"}, n, exp);
    if (!hold) begin
      b16.Run = 1'b0;
      b32.Run = 1'b0;
      @(negedge Clock);
    end
  endtask

  initial begin
    Resetn  = 1'b0;
    b16.Run = 1'b0;
    b32.Run = 1'b0;
    pk16    = 1'b0;
    pk32    = 1'b0;
    pk_a    = '0;
    pk_d    = '0;

    poke(0, 8'd0,  enc(OP_MV,  1, 3'd0, 9'd5));
    poke(0, 8'd1,  enc(OP_MVT, 1, 3'd1, 9'h12));
    poke(0, 8'd2,  enc(OP_ADD, 0, 3'd0, 9'd1));
    poke(0, 8'd3,  enc(OP_MV,  1, 3'd2, 9'h1FF));
    poke(0, 8'd4,  enc(OP_MV,  1, 3'd3, 9'h20));
    poke(0, 8'd5,  enc(OP_ST,  0, 3'd2, 9'd3));
    poke(0, 8'd6,  enc(OP_LD,  0, 3'd4, 9'd3));
    poke(0, 8'd7,  enc(OP_MV,  1, 3'd0, 9'd3));
    poke(0, 8'd8,  enc(OP_CMP, 1, 3'd0, 9'd3));
    poke(0, 8'd9,  enc(OP_MVT, 0, CC_EQ, 9'd2));
    poke(0, 8'd10, enc(OP_MV,  1, 3'd5, 9'd1));
    poke(0, 8'd11, enc(OP_MV,  1, 3'd5, 9'd1));
    poke(0, 8'd12, enc(OP_MVT, 0, CC_NE, 9'd2));
    poke(0, 8'd13, enc(OP_MV,  1, 3'd0, 9'd0));
    poke(0, 8'd14, enc(OP_SUB, 1, 3'd0, 9'd1));
    poke(0, 8'd15, enc(OP_AND, 1, 3'd0, 9'd0));
    poke(0, 8'd16, enc(OP_MV,  1, 3'd6, 9'd7));
    poke(0, 8'd17, enc(OP_ST,  0, 3'd6, 9'd3));
    poke(1, 8'd0,  enc(OP_MVT, 1, 3'd5, 9'hAB));
    poke(1, 8'd1,  enc(OP_MVT, 0, CC_AL, 9'h1FF));
    repeat (2) @(negedge Clock);

    check("rst Done", 32'(b16.Done), 0);
    check("rst Wr", 32'(b16.Wr), 0);
    check("rst ADDR", 32'(b16.ADDR), 0);
    check("rst DOUT", 32'(b16.DOUT), 0);
    check("rst state", 32'(dut16.state), 32'(S_IDLE));
    check("rst pc", 32'(dut16.rf[7]), 0);
    Resetn = 1'b1;

    exec("mv r0", 4, 1, 0);
    exec("mvt r1", 4, 1, 0);
    exec("add", 6, 0, 0);
    check("r1 mvt", 32'(dut16.rf[1]), 32'h1200);
    check("r0 add", 32'(dut16.rf[0]), 32'h1205);

    exec("mv r2", 4, 0, 0);
    exec("mv r3", 4, 0, 0);
    exec("st", 6, 0, 0);
    check("st wr count", wr_cnt, 1);
    check("st addr", 32'(wr_a), 32'h20);
    check("st data", 32'(wr_d), 32'h1FF);
    check("st wr in done", 32'(wr_done), 1);
    check("st mem", 32'(m16[32]), 32'h1FF);
    exec("ld", 6, 0, 0);
    check("ld r4", 32'(dut16.rf[4]), 32'h1FF);

    exec("mv r0 3", 4, 0, 0);
    exec("cmp", 5, 0, 0);
    check("cmp Z", 32'(dut16.zf), 1);
    check("cmp C", 32'(dut16.cf), 0);
    check("cmp N", 32'(dut16.nf), 0);
    check("cmp r0 kept", 32'(dut16.rf[0]), 3);
    exec("beq", 6, 0, 0);
    check("beq pc", 32'(dut16.rf[7]), 12);
    exec("bne", 5, 0, 0);
    check("bne pc", 32'(dut16.rf[7]), 13);
    check("skipped r5", 32'(dut16.rf[5]), 0);

    exec("mv r0 0", 4, 0, 0);
    exec("sub", 6, 0, 0);
    check("sub r0", 32'(dut16.rf[0]), 32'hFFFF);
    check("sub C", 32'(dut16.cf), 1);
    check("sub N", 32'(dut16.nf), 1);
    check("sub Z", 32'(dut16.zf), 0);
    exec("and", 6, 0, 0);
    check("and r0", 32'(dut16.rf[0]), 0);
    check("and Z", 32'(dut16.zf), 1);
    check("and C", 32'(dut16.cf), 0);

    exec("mv r6", 4, 0, 0);
    b16.Run = 1'b1;
    repeat (5) @(negedge Clock);
    check("st at E2", 32'(dut16.state), 32'(S_E2));
    b16.Run = 1'b0;
    Resetn  = 1'b0;
    @(negedge Clock);
    Resetn  = 1'b1;
    check("rr Wr", 32'(b16.Wr), 0);
    check("rr Done", 32'(b16.Done), 0);
    check("rr state", 32'(dut16.state), 32'(S_IDLE));
    check("rr r3", 32'(dut16.rf[3]), 0);
    check("rr r6", 32'(dut16.rf[6]), 0);
    check("rr pc", 32'(dut16.rf[7]), 0);
    check("rr Z", 32'(dut16.zf), 0);
    check("rr ADDR", 32'(b16.ADDR), 0);
    check("rr mem kept", 32'(m16[32]), 32'h1FF);
    check("rr wr count", wr_cnt, 1);
    exec("restart", 4, 0, 0);
    check("restart r0", 32'(dut16.rf[0]), 5);
    check("restart pc", 32'(dut16.rf[7]), 1);

    exec("mvt32", 4, 0, 1);
    check("r5 w32", dut32.rf[5], 32'hAB000000);
    exec("bback32", 6, 0, 1);
    check("pc w32", dut32.rf[7], 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
